// File: rtl/mux_pipe_stage_if.sv
// Handshake bundle for mux_pipe_stage: packed sources with select on the upstream side,
// registered data on the downstream side, plus the stage-wide load/flush controls.
interface mux_pipe_stage_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 2
);
   localparam int SEL_W = $clog2(NUM_SRC);

   logic [NUM_SRC*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]         in_sel;
   logic                     in_valid;
   logic                     in_ready;
   logic                     load;
   logic                     flush;
   logic [WIDTH-1:0]         out_data;
   logic                     out_valid;
   logic                     out_ready;

   // master drives beats and controls; slave is the pipeline stage itself
   modport master (
      output in_data, in_sel, in_valid, load, flush, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_sel, in_valid, load, flush, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/mux_pipe_stage.sv
// Registered N:1 select stage with valid/ready handshake, stall, flush-to-NOP and a
// one-entry skid buffer so that in_ready depends only on registered state and load.
module mux_pipe_stage #(
   parameter int          WIDTH     = 32,
   parameter int          NUM_SRC   = 2,
   parameter logic [31:0] NOP_VALUE = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   mux_pipe_stage_if.slave  bus
);
   localparam int               SEL_W = $clog2(NUM_SRC);
   localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_skid_data;
   logic             r_skid_valid;

   logic [WIDTH-1:0] w_sel_data;
   logic             w_in_ready;
   logic             w_in_xfer;
   logic             w_out_xfer;

   // Out-of-range selects fall through to the NOP so no X ever enters the pipe.
   always_comb begin
      // NOTE: default assigned first so every path drives w_sel_data and no latch is inferred.
      w_sel_data = NOP_W;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_in_ready = bus.load & ~r_skid_valid;
   assign w_in_xfer  = bus.in_valid & w_in_ready;
   assign w_out_xfer = r_out_valid & bus.out_ready & bus.load;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if (rst) begin
         r_out_data   <= NOP_W;
         r_out_valid  <= 1'b0;
         // NOTE: skid data is a plain register, not a memory, so it gets a defined reset value.
         r_skid_data  <= NOP_W;
         r_skid_valid <= 1'b0;
      end else if (bus.flush) begin
         r_out_data   <= NOP_W;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (bus.load) begin
         if (!r_out_valid || w_out_xfer) begin
            if (r_skid_valid) begin
               r_out_data   <= r_skid_data;
               r_out_valid  <= 1'b1;
               r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
               r_out_data  <= w_sel_data;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_in_xfer) begin
            // Main register is held by backpressure; park the beat behind it.
            r_skid_data  <= w_sel_data;
            r_skid_valid <= 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: a 4-source instance checked by an in-order scoreboard plus
// directed checks, and a 3-source instance exercising the out-of-range select.
module tb_mux_pipe_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   logic [31:0] src4 [4];
   logic [31:0] src3 [3];
   logic [31:0] sb_q [$];

   mux_pipe_stage_if #(.WIDTH(32), .NUM_SRC(4)) bus4 ();
   mux_pipe_stage_if #(.WIDTH(32), .NUM_SRC(3)) bus3 ();

   mux_pipe_stage #(.WIDTH(32), .NUM_SRC(4), .NOP_VALUE(NOP)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   mux_pipe_stage #(.WIDTH(32), .NUM_SRC(3), .NOP_VALUE(NOP)) u_dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model4(input logic [1:0] sel);
      return src4[sel];
   endfunction

   // Scoreboard monitor: samples mid-cycle, pops on out_xfer, then pushes on in_xfer.
   always @(negedge clk) begin
      if (rst || bus4.flush) begin
         sb_q.delete();
      end else begin
         if (bus4.out_valid && bus4.out_ready && bus4.load) begin
            if (sb_q.size() == 0) begin
               check("sb_pop_empty", 32'(sb_q.size()), 32'd1);
            end else begin
               check("sb_data", bus4.out_data, sb_q.pop_front());
            end
         end
         if (bus4.in_valid && bus4.in_ready) begin
            sb_q.push_back(model4(bus4.in_sel));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      src4[0] = 32'hAAAA_00A0;
      src4[1] = 32'hBBBB_00B1;
      src4[2] = 32'hCCCC_00C2;
      src4[3] = 32'hDDDD_00D3;
      src3[0] = 32'h1111_0A00;
      src3[1] = 32'h2222_0B01;
      src3[2] = 32'h3333_0C02;

      rst            = 1'b1;
      bus4.in_data   = {src4[3], src4[2], src4[1], src4[0]};
      bus4.in_sel    = 2'd0;
      bus4.in_valid  = 1'b1;
      bus4.load      = 1'b0;
      bus4.flush     = 1'b0;
      bus4.out_ready = 1'b1;
      bus3.in_data   = {src3[2], src3[1], src3[0]};
      bus3.in_sel    = 2'd0;
      bus3.in_valid  = 1'b1;
      bus3.load      = 1'b0;
      bus3.flush     = 1'b0;
      bus3.out_ready = 1'b1;

      // Reset held two cycles with a beat offered
      tick();
      tick();
      check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      check("rst_out_data", bus4.out_data, NOP);
      check("rst_in_ready", 32'(bus4.in_ready), 32'd0);
      rst           = 1'b0;
      bus4.load     = 1'b1;
      bus4.in_valid = 1'b0;
      bus3.load     = 1'b1;
      bus3.in_valid = 1'b0;
      #1;
      check("rel_in_ready", 32'(bus4.in_ready), 32'd1);
      tick();

      // Streaming through all four sources, one beat per cycle
      for (int i = 0; i < 4; i++) begin
         bus4.in_sel   = 2'(i);
         bus4.in_valid = 1'b1;
         tick();
         check($sformatf("str_valid_%0d", i), 32'(bus4.out_valid), 32'd1);
         check($sformatf("str_data_%0d", i), bus4.out_data, src4[i]);
      end
      bus4.in_valid = 1'b0;
      tick();
      check("str_drained", 32'(bus4.out_valid), 32'd0);

      // Backpressure: main + skid fill, third beat refused and held upstream
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b1;
      bus4.in_sel    = 2'd0;
      #1;
      check("bp_rdy_1", 32'(bus4.in_ready), 32'd1);
      tick();
      bus4.in_sel = 2'd1;
      check("bp_rdy_2", 32'(bus4.in_ready), 32'd1);
      tick();
      bus4.in_sel = 2'd2;
      check("bp_rdy_3", 32'(bus4.in_ready), 32'd0);
      tick();
      check("bp_full_rdy", 32'(bus4.in_ready), 32'd0);
      check("bp_hold_data", bus4.out_data, src4[0]);
      bus4.out_ready = 1'b1;
      tick();
      check("bp_rel_1", bus4.out_data, src4[1]);
      check("bp_rel_rdy", 32'(bus4.in_ready), 32'd1);
      tick();
      check("bp_rel_2", bus4.out_data, src4[2]);
      bus4.in_valid = 1'b0;
      tick();
      check("bp_drained", 32'(bus4.out_valid), 32'd0);

      // Stall with a full stage and downstream ready
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b1;
      bus4.in_sel    = 2'd3;
      tick();
      bus4.in_sel = 2'd0;
      tick();
      bus4.load      = 1'b0;
      bus4.out_ready = 1'b1;
      bus4.in_sel    = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_valid_%0d", i), 32'(bus4.out_valid), 32'd1);
         check($sformatf("stall_data_%0d", i), bus4.out_data, src4[3]);
         check($sformatf("stall_rdy_%0d", i), 32'(bus4.in_ready), 32'd0);
      end
      bus4.load     = 1'b1;
      bus4.in_valid = 1'b0;
      tick();
      check("stall_resume", bus4.out_data, src4[0]);
      tick();
      check("stall_drained", 32'(bus4.out_valid), 32'd0);

      // Flush with both entries occupied and a beat offered
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b1;
      bus4.in_sel    = 2'd1;
      tick();
      bus4.in_sel = 2'd2;
      tick();
      bus4.flush  = 1'b1;
      bus4.in_sel = 2'd3;
      tick();
      bus4.flush    = 1'b0;
      bus4.in_valid = 1'b0;
      check("fl_valid", 32'(bus4.out_valid), 32'd0);
      check("fl_data", bus4.out_data, NOP);
      check("fl_rdy", 32'(bus4.in_ready), 32'd1);
      bus4.in_sel    = 2'd0;
      bus4.in_valid  = 1'b1;
      bus4.out_ready = 1'b1;
      tick();
      check("fl_next_valid", 32'(bus4.out_valid), 32'd1);
      check("fl_next_data", bus4.out_data, src4[0]);
      bus4.in_valid = 1'b0;
      tick();
      check("fl_drained", 32'(bus4.out_valid), 32'd0);

      // Three-source instance: select 3 is out of range and must yield the NOP
      for (int i = 0; i < 4; i++) begin
         bus3.in_sel   = 2'(i);
         bus3.in_valid = 1'b1;
         tick();
         check($sformatf("oor_valid_%0d", i), 32'(bus3.out_valid), 32'd1);
         check($sformatf("oor_data_%0d", i), bus3.out_data, (i < 3) ? src3[i] : NOP);
      end
      bus3.in_valid = 1'b0;
      tick();
      check("oor_drained", 32'(bus3.out_valid), 32'd0);

      tick();
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
